// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, 1 bit per cycle)
// Ports: clk; rst_n (async, active-low); start/op/op_a/op_b request an operation (sampled in IDLE);
//        busy high in CALC and DONE; done is a one-cycle pulse with o_data valid; o_data held until the next done.
module riscv_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] o_data
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0] m_q, m_d, o_data_q, o_data_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic a_sgn, b_sgn, na, nb, dz, ovf, qbit;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem, res;
  logic [XLEN:0] sum, rsh, rdiff;
  logic [2*XLEN-1:0] step, mres;
  // op_a is signed for MUL/MULH/MULHSU/DIV/REM, op_b for MUL/MULH/DIV/REM
  assign a_sgn = ~(op[0] & (op[2] | op[1]));
  assign b_sgn = op[2] ? ~op[0] : ~op[1];
  assign na = a_sgn & op_a[XLEN-1];
  assign nb = b_sgn & op_b[XLEN-1];
  assign mag_a = na ? -op_a : op_a;
  assign mag_b = nb ? -op_b : op_b;
  assign dz = op[2] & (op_b == '0);
  assign ovf = op[2] & ~op[0] & (op_a == MINV) & (&op_b);
  // prod_q holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
  assign sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod_q[0]}} & m_q};
  assign rsh = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign rdiff = rsh - {1'b0, m_q};
  // partial remainder < divisor, so the top bit of the difference is a clean borrow flag
  assign qbit = ~rdiff[XLEN];
  assign step = op_q[2] ? {qbit ? rdiff[XLEN-1:0] : rsh[XLEN-1:0], prod_q[XLEN-2:0], qbit}
                        : {sum, prod_q[XLEN-1:1]};
  assign mres = (neg_a_q ^ neg_b_q) ? -step : step;
  assign quo = (neg_a_q ^ neg_b_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem = neg_a_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
  assign res = op_q[2] ? (op_q[1] ? rem : quo)
                       : (op_q[1:0] == 2'b00 ? mres[XLEN-1:0] : mres[2*XLEN-1:XLEN]);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    m_d = m_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    o_data_d = o_data_q;
    if (state_q == IDLE && start) begin
      op_d = op;
      neg_a_d = na;
      neg_b_d = nb;
      m_d = mag_b;
      prod_d = {{XLEN{1'b0}}, mag_a};
      cnt_d = '0;
      // divide-by-zero and signed overflow resolve immediately
      state_d = (dz || ovf) ? DONE : CALC;
      o_data_d = dz ? (op[1] ? op_a : '1) : ovf ? (op[1] ? '0 : MINV) : o_data_q;
    end else if (state_q == CALC) begin
      prod_d = step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
        o_data_d = res;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      m_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      o_data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      m_q <= m_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      o_data_q <= o_data_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign o_data = o_data_q;
endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu: directed self-checking bench for riscv_mdu (XLEN=32)
module tb_riscv_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic busy, done;
  logic [31:0] o_data;
  int n_cmp = 0;
  int n_err = 0;
  riscv_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .o_data(o_data)
  );
  always #5 clk = ~clk;
  // launches one op in IDLE; lat = negedges after the accept edge until done (-1 on timeout)
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output int bc);
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    lat = -1;
    bc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
    r = o_data;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp += 3;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", o_data); end
    rst_n = 1'b1;
  endtask
  task automatic test_mul_basic;
    logic [31:0] r;
    int lat, bc;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bc);
    n_cmp += 3;
    if (r !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul_basic got %h want ffffffeb", r); end
    if (lat !== 33) begin n_err++; $display("FAIL mul_latency got %0d want 33", lat); end
    if (bc !== 33) begin n_err++; $display("FAIL mul_busy_cycles got %0d want 33", bc); end
    @(negedge clk);
    n_cmp += 3;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b want 0", done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done got %b want 0", busy); end
    if (o_data !== 32'hFFFFFFEB) begin n_err++; $display("FAIL data_hold got %h want ffffffeb", o_data); end
  endtask
  task automatic test_mul_high;
    logic [2:0] ops [4] = '{3'b011, 3'b001, 3'b010, 3'b000};
    logic [31:0] exp [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};
    logic [31:0] r;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
      n_cmp += 2;
      if (r !== exp[i]) begin n_err++; $display("FAIL mul_ones op=%b got %h want %h", ops[i], r, exp[i]); end
      if (lat !== 33) begin n_err++; $display("FAIL mul_ones_latency op=%b got %0d want 33", ops[i], lat); end
    end
  endtask
  task automatic test_div;
    logic [2:0] ops [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b000};
    logic [31:0] as [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] bs [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd3, 32'd5};
    logic [31:0] exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001,
                             32'hFFFFFFFD, 32'h00000001, 32'h00000000, 32'h00000000};
    logic [31:0] r;
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc);
      n_cmp += 2;
      if (r !== exp[i]) begin n_err++; $display("FAIL div_vec%0d got %h want %h", i, r, exp[i]); end
      if (lat !== 33) begin n_err++; $display("FAIL div_vec%0d_latency got %0d want 33", i, lat); end
    end
  endtask
  task automatic test_div_special;
    logic [2:0] ops [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] as [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] bs [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] r;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc);
      n_cmp += 2;
      if (r !== exp[i]) begin n_err++; $display("FAIL special%0d got %h want %h", i, r, exp[i]); end
      if (lat !== 1) begin n_err++; $display("FAIL special%0d_latency got %0d want 1", i, lat); end
    end
  endtask
  task automatic test_ignore_start;
    int lat = -1;
    int idle_busy = 0;
    @(negedge clk);
    op = 3'b000; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = (k == 5);
      op_a = (k == 5) ? 32'd100 : 32'd6;
      op = (k == 5) ? 3'b100 : 3'b000;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    n_cmp += 2;
    if (o_data !== 32'd42) begin n_err++; $display("FAIL ignore_start got %0d want 42", o_data); end
    if (lat !== 33) begin n_err++; $display("FAIL ignore_start_latency got %0d want 33", lat); end
    repeat (3) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    n_cmp++;
    if (idle_busy !== 0) begin n_err++; $display("FAIL no_queue busy_cycles got %0d want 0", idle_busy); end
  endtask
  task automatic test_reset_abort;
    logic [31:0] r;
    int lat, bc;
    int seen = 0;
    @(negedge clk);
    op = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done); end
    if (o_data !== 32'h0) begin n_err++; $display("FAIL abort_data got %h want 0", o_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL abort_no_done activity got %0d want 0", seen); end
    run_op(3'b000, 32'd3, 32'd4, r, lat, bc);
    n_cmp += 2;
    if (r !== 32'd12) begin n_err++; $display("FAIL post_reset_mul got %0d want 12", r); end
    if (lat !== 33) begin n_err++; $display("FAIL post_reset_latency got %0d want 33", lat); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] r1, r2;
    int l1, l2, b1, b2;
    run_op(3'b011, 32'h00010000, 32'h00010000, r1, l1, b1);
    run_op(3'b101, 32'd1000, 32'd10, r2, l2, b2);
    n_cmp += 4;
    if (r1 !== 32'd1) begin n_err++; $display("FAIL b2b_first got %h want 1", r1); end
    if (r2 !== 32'd100) begin n_err++; $display("FAIL b2b_second got %0d want 100", r2); end
    if (l2 !== 33) begin n_err++; $display("FAIL b2b_latency got %0d want 33", l2); end
    if (b2 !== 33) begin n_err++; $display("FAIL b2b_busy_cycles got %0d want 33", b2); end
  endtask
  initial begin
    test_reset();
    test_mul_basic();
    test_mul_high();
    test_div();
    test_div_special();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_mdu.md
RISCV_MDU -- requirements
Module: riscv_mdu

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width in bits; SHALL support any even XLEN >= 8.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: op  input  3  operation, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: op_a  input  XLEN  first operand (multiplicand / dividend).
REQ-007 Port: op_b  input  XLEN  second operand (multiplier / divisor).
REQ-008 Port: busy  output  1  high while an accepted operation is in progress (CALC or DONE).
REQ-009 Port: done  output  1  single-cycle pulse; o_data is valid for this operation.
REQ-010 Port: o_data  output  XLEN  result; held stable from done until the next done.

Function
REQ-011 States SHALL be IDLE, CALC and DONE; busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-012 IDLE with start=1 SHALL capture op, op_a and op_b into internal registers; later input changes SHALL NOT affect the result.
REQ-013 start SHALL be ignored while busy=1; no queueing.
REQ-014 Normal path: IDLE -> CALC for exactly XLEN cycles -> DONE for 1 cycle -> IDLE; done SHALL be high exactly XLEN+1 cycles after the start-accept edge.
REQ-015 Multiply SHALL use iterative shift-add, 1 multiplier bit per cycle, on operand magnitudes, producing a 2*XLEN product.
REQ-016 Signedness: MUL/MULH treat both operands as signed; MULHSU treats op_a signed and op_b unsigned; MULHU treats both unsigned; DIV/REM signed; DIVU/REMU unsigned.
REQ-017 The result sign SHALL be applied on entry to DONE: the product is negated when exactly one signed operand is negative; the quotient is negated when the dividend and divisor signs differ; the remainder takes the sign of the dividend.
REQ-018 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-019 Divide SHALL use iterative restoring division, 1 quotient bit per cycle, on magnitudes.
REQ-020 Divide by zero: DIV and DIVU SHALL return all ones; REM and REMU SHALL return op_a unchanged.
REQ-021 Signed overflow (DIV/REM with op_a = -2^(XLEN-1) and op_b = -1): DIV SHALL return -2^(XLEN-1); REM SHALL return 0.
REQ-022 The REQ-020/021 cases SHALL bypass CALC (IDLE -> DONE), so done is high 1 cycle after start-accept.
REQ-023 All other cases, including operands of 0, SHALL take the full REQ-014 latency.
REQ-024 A start in the IDLE cycle directly following DONE SHALL be accepted, giving back-to-back throughput of one operation per XLEN+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force state=IDLE, busy=0, done=0, o_data=0 and clear all internal registers.
REQ-026 A reset during CALC or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as in REQ-014.

Verification
REQ-027 XLEN=32. MUL with op_a=7, op_b=0xFFFFFFFD -> o_data=0xFFFFFFEB, done exactly 33 cycles after accept, busy high for 33 cycles.
REQ-028 op_a=op_b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
REQ-029 op_a=0xFFFFFFF9 (-7), op_b=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 0x00000001.
REQ-030 op_b=0 with op_a=5: DIVU -> 0xFFFFFFFF and REMU -> 5, done 1 cycle after accept. op_a=0x80000000, op_b=0xFFFFFFFF: DIV -> 0x80000000 and REM -> 0, done 1 cycle after accept.
REQ-031 Pulse start again, and change op_a, in CALC cycle 5 -> ignored, result unchanged. Assert rst_n=0 in CALC cycle 10 -> busy=0, done=0, o_data=0 at once, no done pulse. A new MUL 3*4 after reset -> 12 after 33 cycles.
